// File: rtl/modinv_sched_pkg.sv
// modinv_pkg: shared definitions for the modular-inverse scheduler.
//   W_DEF / TIMEOUT_DEF : default operand width and watchdog limit
//   ID_W_MAX            : requester index width for the largest supported N (8)
//   sched_state_t       : scheduler FSM states
//   modinv_rsp_t        : one tagged response (requester id, result, error flag)
package modinv_pkg;

  localparam int W_DEF       = 256;
  localparam int TIMEOUT_DEF = 1100;
  localparam int ID_W_MAX    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [W_DEF-1:0]    data;
    logic                err;
  } modinv_rsp_t;

endpackage

// File: rtl/modinv_sched_if.sv
// modinv_sched_if: bundles the requester side, the response port and the
// engine port of the modular-inverse scheduler.
//   req/req_a/mod_p/gnt                  : requester request/grant bus
//   rsp_valid/rsp_ready/rsp_id/data/err  : tagged response handshake
//   eng_start/eng_a/eng_p/eng_b/eng_busy : connection to the single engine
// Modports:
//   master : requesters, response consumer and engine (the environment)
//   slave  : the scheduler itself
interface modinv_sched_if
  import modinv_pkg::*;
#(
  parameter int N = 4,
  parameter int W = W_DEF
);

  localparam int IW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [W-1:0]   mod_p;
  logic [N-1:0]   gnt;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_p;
  logic [W-1:0]   eng_b;
  logic           eng_busy;

  modport master (
    output req, req_a, mod_p, rsp_ready, eng_b, eng_busy,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_a, eng_p
  );

  modport slave (
    input  req, req_a, mod_p, rsp_ready, eng_b, eng_busy,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_a, eng_p
  );

endinterface

// File: rtl/modinv_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last winner; the search starts at ptr+1 (mod N)
//   grant : one-hot winner (all zero when no request)
//   idx   : encoded winner index
//   any   : at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so that the closest
  // requester after the pointer is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/modinv_sched.sv
// modinv_sched: shares one modular-inversion engine among N requesters.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : modinv_sched_if.slave carrying requests (req, req_a, mod_p,
//                gnt), the tagged response (rsp_*) and the engine port (eng_*)
// A zero operand is answered at once with an error because the engine would
// never terminate on it; a watchdog aborts any job that overstays TIMEOUT.
module modinv_sched
  import modinv_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  modinv_sched_if.slave bus
);

  localparam int IW   = $clog2(N);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t  state;
  logic [IW-1:0] ptr;
  logic [N-1:0]  gnt_q;
  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic [W-1:0]  rsp_data_q;
  logic          rsp_err_q;
  logic          eng_start_q;
  logic [W-1:0]  eng_a_q;
  logic [WD_W-1:0] wdog;

  logic [N-1:0]  arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [W-1:0]  sel_a;
  logic          sel_zero;
  logic          wdog_expire;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Operand of the current arbitration winner.
  always_comb begin
    sel_a = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_idx == IW'(i)) sel_a = bus.req_a[i*W +: W];
    end
  end

  assign sel_zero = (sel_a == '0);

  // The watchdog reaches TIMEOUT on the edge where it would step past
  // TIMEOUT-1, i.e. exactly TIMEOUT cycles after eng_start rose.
  assign wdog_expire = (wdog == WD_W'(TIMEOUT - 1));

  // Scheduler FSM. eng_start is low everywhere except LAUNCH/RUN, so the
  // engine sits cleared between jobs and the mandatory IDLE cycle after a
  // response guarantees at least one low cycle before the next launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IW'(N - 1);
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      wdog        <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          eng_start_q <= 1'b0;
          if (arb_any) begin
            gnt_q    <= arb_grant;
            ptr      <= arb_idx;
            rsp_id_q <= arb_idx;
            eng_a_q  <= sel_a;
            if (sel_zero) begin
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              wdog        <= '0;
              eng_start_q <= 1'b1;
              state       <= LAUNCH;
            end
          end
        end

        LAUNCH, RUN: begin
          if (wdog_expire) begin
            wdog        <= WD_W'(TIMEOUT);
            eng_start_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            if (wdog != WD_W'(TIMEOUT)) wdog <= wdog + 1'b1;
            if (state == LAUNCH) begin
              if (bus.eng_busy) state <= RUN;
            end else if (!bus.eng_busy) begin
              // The engine holds B valid from one cycle before busy falls.
              rsp_data_q  <= bus.eng_b;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              eng_start_q <= 1'b0;
              state       <= RESP;
            end
          end
        end

        RESP: begin
          eng_start_q <= 1'b0;
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_a     = eng_a_q;
  assign bus.eng_p     = bus.mod_p;

endmodule

// File: tb/tb_modinv_sched.sv
// tb_modinv_sched: self-checking bench for modinv_sched with a behavioural
// inverter engine (fixed latency, or hanging to exercise the watchdog).
// Expected responses go into a scoreboard queue when requests are driven and
// are popped by a monitor on every response handshake.
module tb_modinv_sched;
  import modinv_pkg::*;

  localparam int N       = 4;
  localparam int W       = W_DEF;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 4;
  localparam logic [W-1:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  modinv_sched_if #(.N(N), .W(W)) ifc ();

  modinv_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int tests_run = 0;
  int tests_failed = 0;

  modinv_rsp_t sb[$];
  int   rsp_count = 0;
  int   gnt_count [N];
  int   start_rises = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   valid_cyc = 0;
  logic start_at_valid = 1'b0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;
  logic [W-1:0] last_data = '0;
  logic hang = 1'b0;
  int   model_ptr = N - 1;
  logic [W-1:0] ops_tbl [N];

  logic running = 1'b0;
  int   cnt = 0;

  // Reference inverse by the classic extended Euclid on wide unsigned values.
  function automatic logic [W-1:0] mod_inv(input logic [W-1:0] a, input logic [W-1:0] p);
    logic [2*W-1:0] r0, r1, t0, t1, q, tmp, pp;
    pp = {{W{1'b0}}, p};
    r0 = pp;
    r1 = {{W{1'b0}}, a};
    t0 = '0;
    t1 = {{(2*W-1){1'b0}}, 1'b1};
    for (int it = 0; it < 2000 && r1 != '0; it++) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + pp - ((q * t1) % pp)) % pp;
      t0  = t1;
      t1  = tmp;
    end
    return t0[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Behavioural engine: busy one clock after start, B latched one cycle
  // before busy falls; start low clears it. In hang mode busy never falls.
  always @(posedge clk) begin
    if (!ifc.eng_start) begin
      ifc.eng_busy <= 1'b0;
      running      <= 1'b0;
      cnt          <= 0;
    end else if (!running) begin
      running      <= 1'b1;
      ifc.eng_busy <= 1'b1;
      cnt          <= LAT;
    end else if (ifc.eng_busy && !hang) begin
      if (cnt == 1) ifc.eng_b <= mod_inv(ifc.eng_a, ifc.eng_p);
      if (cnt == 0) ifc.eng_busy <= 1'b0;
      else          cnt <= cnt - 1;
    end
  end

  // Monitor: grant pulses, eng_start rises, response timing and the
  // scoreboard comparison on each response handshake.
  always @(negedge clk) begin
    modinv_rsp_t e;
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_start <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ifc.gnt[i]) gnt_count[i] <= gnt_count[i] + 1;
      end
      if (ifc.eng_start && !prev_start) begin
        start_rises <= start_rises + 1;
        rise_cyc    <= cyc;
      end
      if (ifc.rsp_valid && !prev_valid) begin
        valid_cyc      <= cyc;
        start_at_valid <= ifc.eng_start;
      end
      prev_start <= ifc.eng_start;
      prev_valid <= ifc.rsp_valid;
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        checkOutput("sb_nonempty", W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("rsp_id", W'(ifc.rsp_id), W'(e.id));
          checkOutput("rsp_err", W'(ifc.rsp_err), W'(e.err));
          checkOutput("rsp_data", ifc.rsp_data, e.data);
          last_data <= ifc.rsp_data;
          rsp_count <= rsp_count + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request and record what its response must look like.
  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic force_err);
    modinv_rsp_t e;
    e.id   = ID_W_MAX'(idx);
    e.err  = (a == '0) || force_err;
    e.data = e.err ? '0 : mod_inv(a, P256);
    sb.push_back(e);
    ifc.req_a[idx*W +: W] = a;
    ifc.req[idx] = 1'b1;
    model_ptr = idx;
  endtask

  task automatic waitResponses(input int target, input int budget);
    for (int c = 0; c < budget && rsp_count < target; c++) begin
      tick();
      ifc.req = ifc.req & ~ifc.gnt;
    end
    checkOutput("responses", W'(rsp_count), W'(target));
  endtask

  // Raise all masked requests at once; the scoreboard order follows the
  // round-robin rotation starting after the last modelled winner.
  task automatic runBatch(input logic [N-1:0] mask, input int budget);
    int base;
    int target;
    int snap [N];
    base   = model_ptr;
    target = rsp_count;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (base + k) % N;
      if (mask[j]) begin
        applyStimulus(j, ops_tbl[j], hang);
        target++;
      end
    end
    for (int i = 0; i < N; i++) snap[i] = gnt_count[i];
    waitResponses(target, budget);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) checkOutput("gnt_once", W'(gnt_count[i] - snap[i]), W'(1));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [2*W-1:0] prod;
    int             rises_snap;
    int             target;
    logic           stable;
    logic           gnt_seen;
    logic [1:0]     cap_id;
    logic [W-1:0]   cap_data;
    logic           cap_err;

    ifc.req       = '0;
    ifc.req_a     = '0;
    ifc.mod_p     = P256;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) ops_tbl[i] = '0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_rsp_valid", W'(ifc.rsp_valid), '0);
    checkOutput("rst_gnt", W'(ifc.gnt), '0);
    checkOutput("rst_eng_start", W'(ifc.eng_start), '0);
    checkOutput("rst_rsp_id", W'(ifc.rsp_id), '0);
    checkOutput("rst_eng_a", ifc.eng_a, '0);
    rst_n = 1'b1;
    tick();

    // Single job from requester 0, a = 3
    checkOutput("idle_eng_start", W'(ifc.eng_start), '0);
    ops_tbl[0] = 3;
    runBatch(4'b0001, 100);
    prod = ({{W{1'b0}}, last_data} * {{W{1'b0}}, W'(3)}) % {{W{1'b0}}, P256};
    checkOutput("inv_product", prod[W-1:0], W'(1));
    checkOutput("post_eng_start", W'(ifc.eng_start), '0);

    // All four requesting, twice, to see the rotation continue
    ops_tbl[0] = 2; ops_tbl[1] = 3; ops_tbl[2] = 5; ops_tbl[3] = 7;
    runBatch(4'b1111, 200);
    ops_tbl[0] = 11; ops_tbl[1] = 13; ops_tbl[2] = 17; ops_tbl[3] = 19;
    runBatch(4'b1111, 200);

    // Zero operand: immediate error, engine never started
    rises_snap = start_rises;
    ops_tbl[2] = '0;
    runBatch(4'b0100, 20);
    checkOutput("zero_no_start", W'(start_rises - rises_snap), '0);

    // Hanging engine: watchdog abort, then a normal job
    hang = 1'b1;
    ops_tbl[3] = 5;
    runBatch(4'b1000, 60);
    checkOutput("wdog_latency", W'(valid_cyc - rise_cyc), W'(TIMEOUT));
    checkOutput("wdog_start_low", W'(start_at_valid), '0);
    hang = 1'b0;
    ops_tbl[0] = 7;
    runBatch(4'b0001, 100);

    // Backpressure with requester 1 waiting
    ifc.rsp_ready = 1'b0;
    target = rsp_count + 2;
    applyStimulus(0, 23, 1'b0);
    for (int c = 0; c < 100 && !ifc.rsp_valid; c++) begin
      tick();
      ifc.req = ifc.req & ~ifc.gnt;
    end
    checkOutput("bp_valid", W'(ifc.rsp_valid), W'(1));
    cap_id = ifc.rsp_id;
    cap_data = ifc.rsp_data;
    cap_err = ifc.rsp_err;
    applyStimulus(1, 29, 1'b0);
    stable = 1'b1;
    gnt_seen = 1'b0;
    repeat (10) begin
      tick();
      if (!ifc.rsp_valid || ifc.rsp_id != cap_id || ifc.rsp_data != cap_data ||
          ifc.rsp_err != cap_err) stable = 1'b0;
      if (ifc.gnt != '0) gnt_seen = 1'b1;
    end
    checkOutput("bp_stable", W'(stable), W'(1));
    checkOutput("bp_no_gnt", W'(gnt_seen), '0);
    ifc.rsp_ready = 1'b1;
    tick();
    checkOutput("bp_idle_gap", W'(ifc.gnt), '0);
    tick();
    checkOutput("bp_gnt1", W'(ifc.gnt), W'(4'b0010));
    ifc.req = ifc.req & ~ifc.gnt;
    waitResponses(target, 100);

    // Reset while the engine is running
    applyStimulus(2, 31, 1'b0);
    for (int c = 0; c < 50 && !ifc.eng_busy; c++) begin
      tick();
      ifc.req = ifc.req & ~ifc.gnt;
    end
    tick();
    ifc.req = ifc.req & ~ifc.gnt;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_eng_start", W'(ifc.eng_start), '0);
    checkOutput("mid_rst_rsp_valid", W'(ifc.rsp_valid), '0);
    checkOutput("mid_rst_eng_a", ifc.eng_a, '0);
    checkOutput("mid_rst_rsp_data", ifc.rsp_data, '0);
    checkOutput("mid_rst_misc", W'({ifc.gnt, ifc.rsp_id, ifc.rsp_err}), '0);
    sb.delete();
    ifc.req = '0;
    model_ptr = N - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    ops_tbl[0] = 37; ops_tbl[1] = 41; ops_tbl[2] = 43; ops_tbl[3] = 47;
    runBatch(4'b1111, 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/modinv_sched.md
Name: modinv_sched

Overview:
- Shares one 256-bit binary-extended-Euclid modular inversion engine (ModInv) among N requesters.
- Round-robin arbitration; sequences the engine's start/busy handshake; screens degenerate operands.
- Bounds run time with a watchdog; returns tagged results over a valid/ready response port.
- Sits between the point-arithmetic units and the single inverter instance.

Parameters:
- N, 4, number of requesters (2..8).
- W, 256, operand/modulus width; must match the engine.
- TIMEOUT, 1100, max cycles from launch to engine completion before abort.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester request level; held until granted.
- req_a  in  N*W  operand per requester; slice i = bits [i*W +: W].
- mod_p  in  W  shared odd modulus; static while not idle.
- gnt  out  N  one-hot, one-cycle pulse when request i is accepted.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(N)  requester index of the result.
- rsp_data  out  W  A^-1 mod p; 0 on error.
- rsp_err  out  1  1 = operand zero or watchdog abort.
- eng_start  out  1  to engine start; low = engine cleared/ready, high = run.
- eng_a  out  W  to engine A; registered, stable while eng_start high.
- eng_p  out  W  to engine p; equals mod_p.
- eng_b  in  W  engine result B.
- eng_busy  in  1  engine busy.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - eng_start=0, eng_a=0, rr pointer=N-1 (requester 0 wins first), watchdog=0.
- IDLE:
  - eng_start=0; this holds the engine cleared.
  - If any req: pick first set bit searching from ptr+1 (mod N). Pulse gnt[i]; latch id=i; latch eng_a=req_a[i]; ptr<=i.
  - If req_a[i]==0: go RESP with err=1, data=0 (engine would never terminate).
  - Otherwise go LAUNCH.
  - Grant decision is combinational on req in IDLE; gnt registered, asserted in the same cycle as the transition.
- LAUNCH:
  - eng_start=1; watchdog counts.
  - On eng_busy=1 go RUN; the engine raises busy one clock after start rises.
- RUN:
  - eng_start=1; watchdog counts.
  - On eng_busy=0: capture rsp_data<=eng_b, err=0; go RESP. The engine latches B one cycle before dropping busy.
- Watchdog:
  - Cleared on entry to LAUNCH.
  - If it reaches TIMEOUT in LAUNCH or RUN: eng_start<=0 (aborts engine), rsp_err=1, rsp_data=0, go RESP.
- RESP:
  - rsp_valid=1; rsp_id/data/err stable.
  - eng_start=0 (engine cleared, not reused until next grant).
  - On rsp_ready=1: rsp_valid<=0, go IDLE.
  - No new grant in the same cycle; minimum one IDLE cycle between jobs, which guarantees start low ≥1 cycle before relaunch.
- Req withdrawn before grant: ignored, no fairness penalty. Req still high after its response: treated as a new request.
- Simultaneous req for all N: grants strictly rotate ptr+1, ptr+2, ...
- eng_busy already 1 on entry to LAUNCH: proceed to RUN immediately. This cannot occur with a correctly cleared engine.
- Reset mid-operation: all outputs return to reset values; eng_start=0 clears the engine; the pending job is lost and no response is issued.
- Widths:
  - eng_a/rsp_data W bits.
  - Watchdog $clog2(TIMEOUT+1) bits, saturating.
  - No arithmetic on operands except the zero compare.

Decomposition:
- Package modinv_pkg:
  - W_DEF=256, TIMEOUT_DEF=1100.
  - State enum {IDLE, LAUNCH, RUN, RESP} as 2-bit typedef sched_state_t.
  - Response struct typedef modinv_rsp_t {id, data, err}.
- One sub-module: rr_arbiter (N-wide, inputs req and ptr, outputs one-hot grant and encoded index; purely combinational).

Test Plan:
- Single job, p=0xFFFFFFFF00000001..., req[0], a=3 → gnt[0] one pulse; rsp_valid with rsp_id=0, rsp_err=0; rsp_data*3 mod p==1; eng_start low ≥1 cycle before launch.
- All four req high, a=2,3,5,7, rsp_ready tied 1 → rsp_id order 0,1,2,3 then 0 again if reasserted; each result verified against a model; exactly one gnt per job.
- req[2] with a=0 → gnt[2] pulse; next cycle rsp_valid=1, rsp_err=1, rsp_data=0; eng_start never rises.
- Stub engine that never drops busy, TIMEOUT=20 → rsp_err=1 exactly 20 cycles after launch; eng_start falls; next request is served normally.
- Backpressure: rsp_ready=0 for 10 cycles with req[1] pending → rsp fields stable, no gnt[1] until 1 cycle after handshake.
- rst_n pulsed low during RUN → all outputs at reset values asynchronously; no rsp_valid; after release, requester 0 is granted first.
